engine_reg_access_master: RTL and testbench

ENGINE_REG_ACCESS_MASTER -- requirements
Module: engine_reg_access_master

---
 rtl/engine_reg_access_master.sv | 170 +++++++++++++++++
 tb/tb_engine_reg_access_master.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/engine_reg_access_master.sv
// Register-bus access master: one command in flight, registered strobes, optional read wait states.
// Define ENGINE_REG_ACCESS_ADDR_CHECK_EN to reject commands addressed above ADDR_MAX.
module engine_reg_access_master #(
    parameter int                ADDR_W   = 33,
    parameter int                DATA_W   = 33,
    parameter int                RDATA_W  = 21,
    parameter int                RD_WAIT  = 1,
    parameter logic [ADDR_W-1:0] ADDR_MAX = 'hFF
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_write,
    input  logic [ADDR_W-1:0]  cmd_addr,
    input  logic [DATA_W-1:0]  cmd_wdata,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [RDATA_W-1:0] rsp_rdata,
    output logic               rsp_err,
    output logic [ADDR_W-1:0]  address,
    output logic               write_enable,
    output logic [DATA_W-1:0]  write_data,
    output logic               read_enable,
    input  logic [RDATA_W-1:0] read_data,
    output logic               busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] WAIT_INIT = 4'(RD_WAIT);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d;
    logic                we_q, we_d;
    logic                re_q, re_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [RDATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;
    logic                cmd_ready_q, cmd_ready_d;
    logic                busy_q, busy_d;
    logic                addr_bad;

`ifdef ENGINE_REG_ACCESS_ADDR_CHECK_EN
    assign addr_bad = (cmd_addr > ADDR_MAX);
`else
    assign addr_bad = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        write_d     = write_q;
        we_d        = we_q;
        re_d        = re_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        cmd_ready_d = cmd_ready_q;

        case (state_q)
            IDLE: begin
                // cmd_ready is registered, so the first IDLE cycle after reset never accepts
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    write_d     = cmd_write;
                    rsp_rdata_d = '0;
                    rsp_err_d   = addr_bad;
                    if (addr_bad) begin
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                    end else begin
                        state_d = ISSUE;
                        addr_d  = cmd_addr;
                        wdata_d = cmd_wdata;
                        we_d    = cmd_write;
                        re_d    = !cmd_write;
                    end
                end
            end
            ISSUE: begin
                we_d = 1'b0;
                if (write_q) begin
                    state_d     = RESP;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                end else if (WAIT_INIT == 4'd0) begin
                    state_d     = RESP;
                    re_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = read_data;
                end else begin
                    state_d = WAIT;
                    cnt_d   = WAIT_INIT;
                end
            end
            WAIT: begin
                // read_data is taken in the last wait cycle, while read_enable is still high
                if (cnt_q <= 4'd1) begin
                    state_d     = RESP;
                    cnt_d       = 4'd0;
                    re_d        = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = read_data;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            addr_q      <= '0;
            wdata_q     <= '0;
            write_q     <= 1'b0;
            we_q        <= 1'b0;
            re_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            write_q     <= write_d;
            we_q        <= we_d;
            re_q        <= re_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign cmd_ready    = cmd_ready_q;
    assign rsp_valid    = rsp_valid_q;
    assign rsp_rdata    = rsp_rdata_q;
    assign rsp_err      = rsp_err_q;
    assign address      = addr_q;
    assign write_data   = wdata_q;
    assign write_enable = we_q;
    assign read_enable  = re_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_engine_reg_access_master.sv
// Scoreboard bench for engine_reg_access_master: RD_WAIT=1 main instance plus an RD_WAIT=0 instance.
module tb_engine_reg_access_master;

    logic        clock = 1'b0;
    logic        reset;
    always #5 clock = ~clock;

    logic        cmd_valid, cmd_ready, cmd_write;
    logic [32:0] cmd_addr, cmd_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [20:0] rsp_rdata;
    logic [32:0] address, write_data;
    logic        write_enable, read_enable, busy;
    logic [20:0] read_data;

    logic        z_cmd_valid, z_cmd_ready, z_cmd_write;
    logic [32:0] z_cmd_addr, z_cmd_wdata;
    logic        z_rsp_valid, z_rsp_ready, z_rsp_err;
    logic [20:0] z_rsp_rdata;
    logic [32:0] z_address, z_write_data;
    logic        z_write_enable, z_read_enable, z_busy;
    logic [20:0] z_read_data;

    engine_reg_access_master #(.RD_WAIT(1)) dut (
        .clock(clock), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .address(address), .write_enable(write_enable), .write_data(write_data),
        .read_enable(read_enable), .read_data(read_data), .busy(busy)
    );

    engine_reg_access_master #(.RD_WAIT(0)) dut0 (
        .clock(clock), .reset(reset),
        .cmd_valid(z_cmd_valid), .cmd_ready(z_cmd_ready), .cmd_write(z_cmd_write),
        .cmd_addr(z_cmd_addr), .cmd_wdata(z_cmd_wdata),
        .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err),
        .address(z_address), .write_enable(z_write_enable), .write_data(z_write_data),
        .read_enable(z_read_enable), .read_data(z_read_data), .busy(z_busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // Register block model: data is only valid in the cycle the master is supposed to sample it
    int re_cyc, z_re_cyc;
    always @(posedge clock) begin
        if (!reset) begin
            re_cyc   <= 0;
            z_re_cyc <= 0;
        end else begin
            re_cyc   <= read_enable   ? re_cyc + 1   : 0;
            z_re_cyc <= z_read_enable ? z_re_cyc + 1 : 0;
        end
    end

    function automatic logic [20:0] reg_model(input logic [32:0] a);
        if (a == 33'hAA) return 21'h0ABCD;
        return a[20:0] ^ 21'h15555;
    endfunction

    always_comb begin
        read_data   = (read_enable   && re_cyc   == 1) ? reg_model(address)   : 21'h1DEAD;
        z_read_data = (z_read_enable && z_re_cyc == 0) ? reg_model(z_address) : 21'h1DEAD;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [20:0] rdata;
        logic        err;
        int          lat;
        int          hs;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    bit   seen = 0;

    int we_run = 0, re_run = 0, last_we_len = 0, last_re_len = 0;
    int we_pulses = 0, re_pulses = 0;
    logic [32:0] we_addr = '0, we_data = '0;

    // Monitor: pops expected response when rsp_valid rises, checks it every valid cycle
    always @(negedge clock) begin
        if (reset && rsp_valid) begin
            if (!seen) begin
                seen = 1;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp actual=rdata %0h required=no response", rsp_rdata);
                    cur = '{rdata: 21'h0, err: 1'b0, lat: 0, hs: cyc};
                end else begin
                    cur = exp_q.pop_front();
                    check("rsp_latency", 64'(cyc - cur.hs), 64'(cur.lat));
                end
            end
            check("rsp_rdata", 64'(rsp_rdata), 64'(cur.rdata));
            check("rsp_err", 64'(rsp_err), 64'(cur.err));
        end else begin
            seen = 0;
        end
        check("we_re_exclusive", 64'(write_enable & read_enable), 64'd0);
        if (write_enable) begin
            we_run++;
            we_addr = address;
            we_data = write_data;
        end else if (we_run > 0) begin
            last_we_len = we_run;
            we_pulses++;
            we_run = 0;
        end
        if (read_enable) re_run++;
        else if (re_run > 0) begin
            last_re_len = re_run;
            re_pulses++;
            re_run = 0;
        end
    end

    task automatic issue(input logic w, input logic [32:0] a, input logic [32:0] d,
                         input logic [20:0] er, input logic ee, input int el);
        int t;
        @(negedge clock);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        t = 0;
        while (!cmd_ready && t < 50) begin
            @(negedge clock);
            t++;
        end
        if (!cmd_ready) begin
            checks++;
            errors++;
            $display("FAIL cmd_handshake_timeout actual=cmd_ready 0 required=1");
        end else begin
            exp_q.push_back('{rdata: er, err: ee, lat: el, hs: cyc});
        end
        @(negedge clock);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t = 0;
        @(negedge clock);
        while (busy && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy 1 required=0");
        end
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int p, r, t, n_re, hs;
        bit got;
        reset = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; rsp_ready = 1'b1;
        z_cmd_valid = 0; z_cmd_write = 0; z_cmd_addr = '0; z_cmd_wdata = '0; z_rsp_ready = 1'b1;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_cmd_ready", 64'(cmd_ready), 64'd0);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_strobes", 64'({write_enable, read_enable}), 64'd0);
        check("rst_address", 64'(address), 64'd0);
        check("rst_write_data", 64'(write_data), 64'd0);
        check("rst_rsp", 64'({rsp_rdata, rsp_err}), 64'd0);
        reset = 1'b1;
        #1 check("rel_cmd_ready_before_edge", 64'(cmd_ready), 64'd0);
        @(negedge clock);
        check("rel_cmd_ready_after_edge", 64'(cmd_ready), 64'd1);

        // Write AA / 1234
        p = we_pulses;
        issue(1'b1, 33'hAA, 33'h1234, 21'h0, 1'b0, 2);
        wait_idle();
        check("wr_pulses", 64'(we_pulses - p), 64'd1);
        check("wr_len", 64'(last_we_len), 64'd1);
        check("wr_addr", 64'(we_addr), 64'hAA);
        check("wr_data", 64'(we_data), 64'h1234);
        check("wr_addr_held", 64'(address), 64'hAA);

        // Read AA with one wait cycle
        r = re_pulses;
        issue(1'b0, 33'hAA, 33'h0, 21'h0ABCD, 1'b0, 3);
        wait_idle();
        check("rd_pulses", 64'(re_pulses - r), 64'd1);
        check("rd_len", 64'(last_re_len), 64'd2);

        // Read 3C
        issue(1'b0, 33'h3C, 33'h0, 21'h15569, 1'b0, 3);
        wait_idle();
        check("rd3c_len", 64'(last_re_len), 64'd2);

        // Response back-pressure with a stray command pulse
        p = we_pulses;
        rsp_ready = 1'b0;
        issue(1'b0, 33'hAA, 33'h0, 21'h0ABCD, 1'b0, 3);
        t = 0;
        while (!rsp_valid && t < 20) begin
            @(negedge clock);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            check("hold_rsp_valid", 64'(rsp_valid), 64'd1);
            check("hold_rsp_rdata", 64'(rsp_rdata), 64'h0ABCD);
            check("hold_cmd_ready", 64'(cmd_ready), 64'd0);
            if (i == 1) begin
                cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 33'h55; cmd_wdata = 33'h5A5A;
            end
            if (i == 2) cmd_valid = 1'b0;
            @(negedge clock);
        end
        rsp_ready = 1'b1;
        wait_idle();
        check("hold_stray_ignored", 64'(we_pulses - p), 64'd0);

        // Reset during WAIT
        @(negedge clock);
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 33'h20;
        check("rstw_cmd_ready", 64'(cmd_ready), 64'd1);
        @(negedge clock);
        cmd_valid = 1'b0;
        check("rstw_issue_re", 64'(read_enable), 64'd1);
        @(negedge clock);
        check("rstw_wait_re", 64'(read_enable), 64'd1);
        #2 reset = 1'b0;
        #1;
        check("rstw_outputs", 64'({cmd_ready, busy, read_enable, write_enable, rsp_valid, rsp_err}), 64'd0);
        check("rstw_rdata", 64'(rsp_rdata), 64'd0);
        check("rstw_address", 64'(address), 64'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("rstw_cmd_ready_after", 64'(cmd_ready), 64'd1);
        p = we_pulses;
        issue(1'b1, 33'h44, 33'h9876, 21'h0, 1'b0, 2);
        wait_idle();
        check("rstw_wr_pulses", 64'(we_pulses - p), 64'd1);
        check("rstw_wr_addr", 64'(we_addr), 64'h44);
        check("rstw_wr_data", 64'(we_data), 64'h9876);

        // Write above ADDR_MAX
        p = we_pulses;
        r = re_pulses;
`ifdef ENGINE_REG_ACCESS_ADDR_CHECK_EN
        issue(1'b1, 33'h100, 33'h77, 21'h0, 1'b1, 1);
        wait_idle();
        check("oor_no_we", 64'(we_pulses - p), 64'd0);
        check("oor_no_re", 64'(re_pulses - r), 64'd0);
        check("oor_addr_kept", 64'(address), 64'h44);
`else
        issue(1'b1, 33'h100, 33'h77, 21'h0, 1'b0, 2);
        wait_idle();
        check("oor_we_pulse", 64'(we_pulses - p), 64'd1);
        check("oor_no_re", 64'(re_pulses - r), 64'd0);
        check("oor_wr_addr", 64'(we_addr), 64'h100);
`endif

        // RD_WAIT=0 instance: single-cycle read strobe
        @(negedge clock);
        z_cmd_valid = 1'b1; z_cmd_write = 1'b0; z_cmd_addr = 33'h3C;
        hs = cyc;
        check("z_cmd_ready", 64'(z_cmd_ready), 64'd1);
        @(negedge clock);
        z_cmd_valid = 1'b0;
        n_re = 0;
        got = 0;
        for (int k = 0; k < 20 && !got; k++) begin
            if (z_read_enable) n_re++;
            if (z_rsp_valid) begin
                got = 1;
                check("z_latency", 64'(cyc - hs), 64'd2);
                check("z_rdata", 64'(z_rsp_rdata), 64'h15569);
                check("z_err", 64'(z_rsp_err), 64'd0);
            end else begin
                @(negedge clock);
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL z_rsp_timeout actual=rsp_valid 0 required=1");
        end
        check("z_re_len", 64'(n_re), 64'd1);

        repeat (3) @(negedge clock);
        #1;
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
